// File: rtl/ea_sequencer.sv
// Effective-address sequencer for the 6502 core: drives the shared ALU for address adds and
// the zero-page read port. Optional build macro PAGE_SKIP_EN skips ADD_HI when no page is crossed.
`timescale 1ns/1ps

module ea_sequencer #(
  parameter logic [7:0] ZP_PAGE = 8'h00
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        start_i,
  input  logic [2:0]  mode_i,
  input  logic [7:0]  op_lo_i,
  input  logic [7:0]  op_hi_i,
  input  logic [7:0]  idx_x_i,
  input  logic [7:0]  idx_y_i,
  output logic        busy_o,
  output logic [15:0] ea_o,
  output logic        ea_valid_o,
  output logic        page_cross_o,
  output logic        alu_sel_o,
  output logic [1:0]  alu_opcode_o,
  output logic [7:0]  alu_a_o,
  output logic [7:0]  alu_b_o,
  input  logic [7:0]  alu_out_i,
  input  logic        alu_carry_i,
  output logic        rd_en_o,
  output logic [15:0] rd_addr_o,
  input  logic [7:0]  rd_data_i
);

  localparam logic [2:0] ModeZp   = 3'b000;
  localparam logic [2:0] ModeZpx  = 3'b001;
  localparam logic [2:0] ModeZpy  = 3'b010;
  localparam logic [2:0] ModeAbs  = 3'b011;
  localparam logic [2:0] ModeAbsx = 3'b100;
  localparam logic [2:0] ModeAbsy = 3'b101;
  localparam logic [2:0] ModeIndx = 3'b110;
  localparam logic [2:0] ModeIndy = 3'b111;

  localparam logic [1:0] OpAdr0 = 2'b00;
  localparam logic [1:0] OpAdr1 = 2'b01;

  typedef enum logic [2:0] {
    StIdle,
    StZadd,
    StRdLo,
    StRdHi,
    StRdCap,
    StAddLo,
    StAddHi,
    StDone
  } state_e;

  state_e      state_q, state_d;
  logic [2:0]  mode_q, mode_d;
  logic [7:0]  base_lo_q, base_lo_d;
  logic [7:0]  base_hi_q, base_hi_d;
  logic [7:0]  index_q, index_d;
  logic [7:0]  ptr_q, ptr_d;
  logic [15:0] ea_q, ea_d;
  logic        page_cross_q, page_cross_d;
  logic [7:0]  ptr_inc;

  // Pointer high-byte fetch wraps within the zero page, so no carry out of this add.
  assign ptr_inc = ptr_q + 8'd1;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q      <= StIdle;
      mode_q       <= ModeZp;
      base_lo_q    <= 8'h00;
      base_hi_q    <= 8'h00;
      index_q      <= 8'h00;
      ptr_q        <= 8'h00;
      ea_q         <= 16'h0000;
      page_cross_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      mode_q       <= mode_d;
      base_lo_q    <= base_lo_d;
      base_hi_q    <= base_hi_d;
      index_q      <= index_d;
      ptr_q        <= ptr_d;
      ea_q         <= ea_d;
      page_cross_q <= page_cross_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    mode_d       = mode_q;
    base_lo_d    = base_lo_q;
    base_hi_d    = base_hi_q;
    index_d      = index_q;
    ptr_d        = ptr_q;
    ea_d         = ea_q;
    page_cross_d = page_cross_q;
    alu_sel_o    = 1'b0;
    alu_opcode_o = OpAdr0;
    alu_a_o      = 8'h00;
    alu_b_o      = 8'h00;
    rd_en_o      = 1'b0;
    rd_addr_o    = 16'h0000;

    unique case (state_q)
      StIdle: begin
        if (start_i) begin
          mode_d       = mode_i;
          base_lo_d    = op_lo_i;
          base_hi_d    = op_hi_i;
          ptr_d        = op_lo_i;
          page_cross_d = 1'b0;
          // Only one index register is ever used per mode; keep just that one.
          if (mode_i == ModeZpx || mode_i == ModeAbsx || mode_i == ModeIndx) begin
            index_d = idx_x_i;
          end else begin
            index_d = idx_y_i;
          end
          case (mode_i)
            ModeZp: begin
              ea_d    = {ZP_PAGE, op_lo_i};
              state_d = StDone;
            end
            ModeAbs: begin
              ea_d    = {op_hi_i, op_lo_i};
              state_d = StDone;
            end
            ModeZpx, ModeZpy, ModeIndx: state_d = StZadd;
            ModeAbsx, ModeAbsy:         state_d = StAddLo;
            default:                    state_d = StRdLo;
          endcase
        end
      end
      StZadd: begin
        alu_sel_o    = 1'b1;
        alu_opcode_o = OpAdr0;
        alu_a_o      = base_lo_q;
        alu_b_o      = index_q;
        ptr_d        = alu_out_i;
        if (mode_q == ModeIndx) begin
          state_d = StRdLo;
        end else begin
          ea_d    = {ZP_PAGE, alu_out_i};
          state_d = StDone;
        end
      end
      StRdLo: begin
        rd_en_o   = 1'b1;
        rd_addr_o = {ZP_PAGE, ptr_q};
        state_d   = StRdHi;
      end
      StRdHi: begin
        rd_en_o   = 1'b1;
        rd_addr_o = {ZP_PAGE, ptr_inc};
        base_lo_d = rd_data_i;
        state_d   = StRdCap;
      end
      StRdCap: begin
        base_hi_d = rd_data_i;
        if (mode_q == ModeIndx) begin
          ea_d    = {rd_data_i, base_lo_q};
          state_d = StDone;
        end else begin
          state_d = StAddLo;
        end
      end
      StAddLo: begin
        alu_sel_o    = 1'b1;
        alu_opcode_o = OpAdr0;
        alu_a_o      = base_lo_q;
        alu_b_o      = index_q;
        ea_d[7:0]    = alu_out_i;
        page_cross_d = alu_carry_i;
`ifdef PAGE_SKIP_EN
        if (!alu_carry_i) begin
          ea_d[15:8] = base_hi_q;
          state_d    = StDone;
        end else begin
          state_d = StAddHi;
        end
`else
        state_d = StAddHi;
`endif
      end
      StAddHi: begin
        // ALU adds the carry it held from the preceding ADR0 cycle.
        alu_sel_o    = 1'b1;
        alu_opcode_o = OpAdr1;
        alu_a_o      = 8'h00;
        alu_b_o      = base_hi_q;
        ea_d[15:8]   = alu_out_i;
        state_d      = StDone;
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  assign busy_o       = (state_q != StIdle);
  assign ea_valid_o   = (state_q == StDone);
  assign ea_o         = ea_q;
  assign page_cross_o = page_cross_q;

endmodule

// File: tb/tb_ea_sequencer.sv
// Directed-vector bench for ea_sequencer with a behavioural ALU and synchronous zero-page RAM.
`timescale 1ns/1ps

module tb_ea_sequencer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [2:0]  mode = 3'd0;
  logic [7:0]  op_lo = 8'h00, op_hi = 8'h00, idx_x = 8'h00, idx_y = 8'h00;
  logic        busy, ea_valid, page_cross, alu_sel, rd_en;
  logic [15:0] ea, rd_addr;
  logic [1:0]  alu_opcode;
  logic [7:0]  alu_a, alu_b, alu_out;
  logic        alu_carry;
  logic [7:0]  rd_data = 8'h00;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  ea_sequencer #(.ZP_PAGE(8'h00)) dut (
    .clk_i        (clk),
    .rst_ni       (rst_n),
    .start_i      (start),
    .mode_i       (mode),
    .op_lo_i      (op_lo),
    .op_hi_i      (op_hi),
    .idx_x_i      (idx_x),
    .idx_y_i      (idx_y),
    .busy_o       (busy),
    .ea_o         (ea),
    .ea_valid_o   (ea_valid),
    .page_cross_o (page_cross),
    .alu_sel_o    (alu_sel),
    .alu_opcode_o (alu_opcode),
    .alu_a_o      (alu_a),
    .alu_b_o      (alu_b),
    .alu_out_i    (alu_out),
    .alu_carry_i  (alu_carry),
    .rd_en_o      (rd_en),
    .rd_addr_o    (rd_addr),
    .rd_data_i    (rd_data)
  );

  // ALU model: ADR0 = a+b, ADR1 = a+b+carry held from the previous ADR0.
  logic       carry_q;
  logic [8:0] sum;
  assign sum = {1'b0, alu_a} + {1'b0, alu_b} +
               ((alu_opcode == 2'b01) ? {8'h00, carry_q} : 9'h000);
  assign alu_out   = sum[7:0];
  assign alu_carry = (alu_opcode == 2'b00) ? sum[8] : carry_q;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) carry_q <= 1'b0;
    else if (alu_sel && alu_opcode == 2'b00) carry_q <= sum[8];
  end

  logic [7:0] mem [256];
  always @(posedge clk) begin
    if (rd_en) rd_data <= mem[rd_addr[7:0]];
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  typedef struct {
    string       name;
    logic [2:0]  mode;
    logic [7:0]  lo, hi, x, y;
    logic [7:0]  m0a, m0d, m1a, m1d;
    logic [15:0] ea;
    logic        pc;
    int          lat;
    int          nrd;
    logic [15:0] rd0, rd1;
  } vec_t;

  function automatic vec_t mk(input string name, input logic [2:0] m, input logic [7:0] lo,
                              input logic [7:0] hi, input logic [7:0] x, input logic [7:0] y,
                              input logic [7:0] m0a, input logic [7:0] m0d,
                              input logic [7:0] m1a, input logic [7:0] m1d,
                              input logic [15:0] e, input logic pc, input int lat,
                              input int nrd, input logic [15:0] rd0, input logic [15:0] rd1);
    vec_t v;
    v.name = name; v.mode = m; v.lo = lo; v.hi = hi; v.x = x; v.y = y;
    v.m0a = m0a; v.m0d = m0d; v.m1a = m1a; v.m1d = m1d;
    v.ea = e; v.pc = pc; v.lat = lat; v.nrd = nrd; v.rd0 = rd0; v.rd1 = rd1;
    return v;
  endfunction

  // Per-run observations, indexed by cycle after the start edge.
  int          lat_g;
  int          nrd_g;
  logic [15:0] rd_log [8];
  logic        sel_log [32];
  logic [1:0]  opc_log [32];
  logic [7:0]  a_log [32];
  logic [7:0]  b_log [32];
  logic [15:0] ea_cap;
  logic        pc_cap;

  task automatic run_seq(input logic [2:0] m, input logic [7:0] lo, input logic [7:0] hi,
                         input logic [7:0] x, input logic [7:0] y);
    bit done;
    @(negedge clk);
    mode = m; op_lo = lo; op_hi = hi; idx_x = x; idx_y = y; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    lat_g = 1; nrd_g = 0; done = 0;
    while (!done && lat_g <= 20) begin
      sel_log[lat_g] = alu_sel; opc_log[lat_g] = alu_opcode;
      a_log[lat_g] = alu_a; b_log[lat_g] = alu_b;
      if (rd_en && nrd_g < 8) begin
        rd_log[nrd_g] = rd_addr;
        nrd_g++;
      end
      if (ea_valid) begin
        done = 1; ea_cap = ea; pc_cap = page_cross;
      end else begin
        @(negedge clk);
        lat_g++;
      end
    end
    if (!done) lat_g = -1;
  endtask

`ifdef PAGE_SKIP_EN
  localparam int LatAbsNoCross  = 2;
  localparam int LatIndyNoCross = 5;
`else
  localparam int LatAbsNoCross  = 3;
  localparam int LatIndyNoCross = 6;
`endif

  vec_t vecs [9];
  int   cnt;

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 8'h00;

    vecs[0] = mk("absx_cross", 3'b100, 8'hF0, 8'h12, 8'h20, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00,
                 16'h1310, 1'b1, 3, 0, 16'h0, 16'h0);
    vecs[1] = mk("zp", 3'b000, 8'h44, 8'h99, 8'h11, 8'h22, 8'h00, 8'h00, 8'h00, 8'h00,
                 16'h0044, 1'b0, 1, 0, 16'h0, 16'h0);
    vecs[2] = mk("abs", 3'b011, 8'h34, 8'h12, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00,
                 16'h1234, 1'b0, 1, 0, 16'h0, 16'h0);
    vecs[3] = mk("zpx_wrap", 3'b001, 8'hF0, 8'h55, 8'h20, 8'h03, 8'h00, 8'h00, 8'h00, 8'h00,
                 16'h0010, 1'b0, 2, 0, 16'h0, 16'h0);
    vecs[4] = mk("zpy", 3'b010, 8'h10, 8'h00, 8'h07, 8'h05, 8'h00, 8'h00, 8'h00, 8'h00,
                 16'h0015, 1'b0, 2, 0, 16'h0, 16'h0);
    vecs[5] = mk("absy_nocross", 3'b101, 8'h00, 8'h12, 8'h40, 8'h05, 8'h00, 8'h00, 8'h00,
                 8'h00, 16'h1205, 1'b0, LatAbsNoCross, 0, 16'h0, 16'h0);
    vecs[6] = mk("indx", 3'b110, 8'hFF, 8'h00, 8'h01, 8'h00, 8'h00, 8'h34, 8'h01, 8'h12,
                 16'h1234, 1'b0, 5, 2, 16'h0000, 16'h0001);
    vecs[7] = mk("indy_cross", 3'b111, 8'hFF, 8'h00, 8'h00, 8'h20, 8'hFF, 8'hF0, 8'h00, 8'h12,
                 16'h1310, 1'b1, 6, 2, 16'h00FF, 16'h0000);
    vecs[8] = mk("indy_nocross", 3'b111, 8'hFF, 8'h00, 8'h00, 8'h05, 8'hFF, 8'hF0, 8'h00,
                 8'h12, 16'h12F5, 1'b0, LatIndyNoCross, 2, 16'h00FF, 16'h0000);

    repeat (2) @(negedge clk);
    chk("reset_busy", {31'd0, busy}, 32'd0);
    chk("reset_ea", {16'd0, ea}, 32'h0);
    chk("reset_flags", {27'd0, ea_valid, page_cross, alu_sel, rd_en, 1'b0}, 32'd0);
    chk("reset_alu", {14'd0, alu_opcode, alu_a, alu_b}, 32'd0);
    chk("reset_rd_addr", {16'd0, rd_addr}, 32'd0);
    rst_n = 1'b1;

    foreach (vecs[i]) begin
      mem[vecs[i].m0a] = vecs[i].m0d;
      mem[vecs[i].m1a] = vecs[i].m1d;
      run_seq(vecs[i].mode, vecs[i].lo, vecs[i].hi, vecs[i].x, vecs[i].y);
      chk({vecs[i].name, "_lat"}, lat_g, vecs[i].lat);
      chk({vecs[i].name, "_ea"}, {16'd0, ea_cap}, {16'd0, vecs[i].ea});
      chk({vecs[i].name, "_pc"}, {31'd0, pc_cap}, {31'd0, vecs[i].pc});
      chk({vecs[i].name, "_nrd"}, nrd_g, vecs[i].nrd);
      if (vecs[i].nrd == 2 && nrd_g == 2) begin
        chk({vecs[i].name, "_rd0"}, {16'd0, rd_log[0]}, {16'd0, vecs[i].rd0});
        chk({vecs[i].name, "_rd1"}, {16'd0, rd_log[1]}, {16'd0, vecs[i].rd1});
      end
      @(negedge clk);
      chk({vecs[i].name, "_pulse_end"}, {30'd0, ea_valid, busy}, 32'd0);
    end

    // ABSX: ADR0 then ADR1 on consecutive cycles with the right operands.
    run_seq(3'b100, 8'hF0, 8'h12, 8'h20, 8'h00);
    chk("absx_c1_alu", {13'd0, sel_log[1], opc_log[1], a_log[1], b_log[1]},
        {13'd0, 1'b1, 2'b00, 8'hF0, 8'h20});
    chk("absx_c2_alu", {13'd0, sel_log[2], opc_log[2], b_log[2]}, {13'd0, 1'b1, 2'b01, 8'h12});
    chk("absx_c3_alu_free", {31'd0, sel_log[3]}, 32'd0);

    // Extra starts during INDX (mid-sequence and in DONE) must be ignored.
    mem[8'h00] = 8'h34; mem[8'h01] = 8'h12;
    @(negedge clk);
    mode = 3'b110; op_lo = 8'hFF; idx_x = 8'h01; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    cnt = 0;
    for (int c = 1; c <= 14; c++) begin
      if (ea_valid) cnt++;
      mode = 3'b011; op_hi = 8'hEE; op_lo = 8'hEE;
      start = (c == 2 || c == 5);
      @(negedge clk);
    end
    start = 1'b0;
    chk("dbl_start_valid_count", cnt, 1);
    chk("dbl_start_ea", {16'd0, ea}, 32'h1234);

    // Reset asserted during RD_HI of an INDY sequence.
    mem[8'hFF] = 8'hF0; mem[8'h00] = 8'h12;
    @(negedge clk);
    mode = 3'b111; op_lo = 8'hFF; idx_y = 8'h20; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    chk("rst_mid_in_rd_hi", {15'd0, rd_en, rd_addr}, {15'd0, 1'b1, 16'h0000});
    rst_n = 1'b0;
    #1;
    chk("rst_mid_ctrl", {29'd0, busy, rd_en, alu_sel}, 32'd0);
    chk("rst_mid_ea", {16'd0, ea}, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    run_seq(3'b011, 8'hCD, 8'hAB, 8'h00, 8'h00);
    chk("post_rst_abs_lat", lat_g, 1);
    chk("post_rst_abs_ea", {16'd0, ea_cap}, 32'hABCD);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running, expected finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/ea_sequencer.md
Name: ea_sequencer

Overview:
Multi-cycle effective-address generator for the 6502 core. It drives the arithmetic unit's address-add opcodes (ADR0 low-byte add, then ADR1 carry-plus-high-byte add) and the zero-page read port, covering all 6502 indexed and indirect addressing modes. It runs between operand fetch and the data access, and delivers a 16-bit effective address plus a page-cross flag to the control unit.

Parameters:
ZP_PAGE, 8'h00, high byte used for zero-page and pointer reads (zero-page wrap page)

Ports:
clk  in  1  system clock, rising edge
reset_n  in  1  asynchronous active-low reset
start  in  1  one-cycle request, sampled only in IDLE
mode  in  3  000 ZP, 001 ZPX, 010 ZPY, 011 ABS, 100 ABSX, 101 ABSY, 110 INDX, 111 INDY
op_lo  in  8  operand byte 1
op_hi  in  8  operand byte 2 (ABS* modes only)
idx_x  in  8  X register
idx_y  in  8  Y register
busy  out  1  sequence in progress
ea  out  16  effective address; holds last value
ea_valid  out  1  one-cycle pulse when ea is final
page_cross  out  1  ABSX/ABSY/INDY low-byte carry; valid with ea_valid, held
alu_sel  out  1  sequencer owns the arithmetic unit; control ignores flags_ena while high
alu_opcode  out  2  00 ADR0 or 01 ADR1; 00 when idle
alu_a  out  8  ALU operand A
alu_b  out  8  ALU operand B
alu_out  in  8  ALU result, combinational
alu_carry  in  1  ALU flags_out[0] during ADR0
rd_en  out  1  zero-page read strobe
rd_addr  out  16  read address, {ZP_PAGE, ptr}
rd_data  in  8  read data, valid the cycle after rd_en (synchronous RAM)

Behaviour:
- Reset: state IDLE; busy, ea_valid, page_cross, alu_sel, rd_en = 0; ea = 0; alu_opcode = 00; alu_a, alu_b, rd_addr = 0. Reset mid-sequence aborts immediately. No ea_valid is produced.
- States: IDLE, ZADD, RD_LO, RD_HI, RD_CAP, ADD_LO, ADD_HI, DONE. Each state lasts one cycle.
- start in IDLE latches mode, op_lo, op_hi, idx_x and idx_y. busy rises on the next cycle and stays high through DONE. start while busy is ignored.
- ZADD: ADR0, a = op_lo (INDX) or op_lo (ZPX/ZPY), b = X or Y. Carry is discarded (zero-page wrap). ptr = alu_out.
- ADD_LO: ADR0, a = base_lo, b = index. Captures ea[7:0] and page_cross = alu_carry.
- ADD_HI: ADR1, b = base_hi. It must occur in the cycle immediately after ADD_LO, because the ALU holds the carry for one cycle. Captures ea[15:8].
- RD_LO: rd_addr = {ZP_PAGE, ptr}. RD_HI: rd_addr = {ZP_PAGE, ptr+1 mod 256}, captures the low byte. RD_CAP: captures the high byte. The 8-bit pointer increment uses a local incrementer, not the ALU.
- Sequences, with latency measured from the start edge to the ea_valid cycle:
  - ZP: DONE. Latency 1, ea = {ZP_PAGE, op_lo}.
  - ABS: DONE. Latency 1, ea = {op_hi, op_lo}.
  - ZPX/ZPY: ZADD, DONE. Latency 2.
  - ABSX/ABSY: ADD_LO, ADD_HI, DONE. Latency 3.
  - INDX: ZADD, RD_LO, RD_HI, RD_CAP, DONE. Latency 5, ea = pointer contents.
  - INDY: RD_LO (ptr = op_lo), RD_HI, RD_CAP, ADD_LO (base = pointer), ADD_HI, DONE. Latency 6.
- DONE: ea_valid = 1 for one cycle, then IDLE. A new start is accepted on the following cycle.
- page_cross = 0 for modes without an ADD_LO.
- alu_sel = 1 only in ZADD, ADD_LO and ADD_HI. rd_en = 1 only in RD_LO and RD_HI.

Optional Feature:
PAGE_SKIP_EN
- Defined: if ADD_LO yields alu_carry = 0, ADD_HI is skipped, ea[15:8] = base_hi, and the FSM goes to DONE. ABSX/ABSY latency drops to 2 and INDY to 5 when no page is crossed.
- Undefined: ADD_HI always runs, and latency is fixed as listed above.

Test Plan:
- ABSX, op=12F0, X=20 -> ea=1310, page_cross=1, ea_valid 3 cycles after start; alu_opcode 00 then 01 on consecutive cycles.
- ZPX, op_lo=F0, X=20 -> ea=0010, page_cross=0, latency 2; ZP, op_lo=44 -> ea=0044, latency 1.
- INDX, op_lo=FF, X=01, mem[0000]=34, mem[0001]=12 -> rd_addr 0000 then 0001, ea=1234, latency 5.
- INDY, op_lo=FF, mem[00FF]=F0, mem[0000]=12, Y=20 -> reads 00FF then 0000 (wrap), ea=1310, page_cross=1, latency 6. With PAGE_SKIP_EN and Y=05 -> ea=12F5, latency 5.
- Second start asserted during an INDX sequence -> ignored; exactly one ea_valid.
- reset_n low during RD_HI -> busy, rd_en, alu_sel drop immediately, ea=0000; the next ABS start (op=ABCD) -> ea=ABCD, latency 1.
